// File: rtl/tpp_pkg.sv
// Shared types and constants for the TPP forward-link encoder.
// The S_CRC state exists only when TPP_ENC_CRC16_EN is defined.
package tpp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELIM,
        S_TCAL1,
        S_TCAL2,
`ifdef TPP_ENC_CRC16_EN
        S_DATA,
        S_CRC
`else
        S_DATA
`endif
    } tpp_state_e;

    // Symbol lengths, expressed in units of U_CYC.
    localparam int MUL_TCAL1 = 16;
    localparam int MUL_TCAL2 = 8;
    localparam int MUL_D00   = 4;
    localparam int MUL_D01   = 7;
    localparam int MUL_D11   = 9;
    localparam int MUL_D10   = 11;

    localparam logic [1:0] SYM_00 = 2'b00;
    localparam logic [1:0] SYM_01 = 2'b01;
    localparam logic [1:0] SYM_11 = 2'b11;
    localparam logic [1:0] SYM_10 = 2'b10;

    localparam logic [15:0] CRC_POLY   = 16'h1021;
    localparam logic [15:0] CRC_PRESET = 16'hFFFF;

    // Two serial CRC-16 steps, d[1] shifted in first.
    function automatic logic [15:0] crc16_step2(input logic [15:0] crc, input logic [1:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 1; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/tpp_crc16.sv
// CRC-16 accumulator taking one 2-bit symbol per update; output is ones-complemented.
module tpp_crc16
    import tpp_pkg::*;
(
    input  logic        dec_clk,
    input  logic        clear,
    input  logic        update,
    input  logic [1:0]  din,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q;

    always_ff @(posedge dec_clk) begin
        if (clear) begin
            crc_q <= CRC_PRESET;
        end else if (update) begin
            crc_q <= crc16_step2(crc_q, din);
        end
    end

    assign crc_out = ~crc_q;

endmodule

// File: rtl/tpp_encoder.sv
// Interrogator-side TPP pulse-position encoder: delimiter, Tcal1, Tcal2, data symbols.
// Optional trailing CRC-16 symbols are built when TPP_ENC_CRC16_EN is defined.
module tpp_encoder
    import tpp_pkg::*;
#(
    parameter int U_CYC     = 8,
    parameter int PW_CYC    = 12,
    parameter int DELIM_CYC = 24
) (
    input  logic       dec_clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [1:0] sym_data,
    input  logic       sym_valid,
    input  logic       sym_last,
    output logic       sym_ready,
    output logic       tx_dout,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       underrun
);

    localparam logic [9:0] LEN_DELIM = 10'(DELIM_CYC);
    localparam logic [9:0] LEN_TCAL1 = 10'(MUL_TCAL1 * U_CYC);
    localparam logic [9:0] LEN_TCAL2 = 10'(MUL_TCAL2 * U_CYC);
    localparam logic [9:0] LEN_D00   = 10'(MUL_D00 * U_CYC);
    localparam logic [9:0] LEN_D01   = 10'(MUL_D01 * U_CYC);
    localparam logic [9:0] LEN_D11   = 10'(MUL_D11 * U_CYC);
    localparam logic [9:0] LEN_D10   = 10'(MUL_D10 * U_CYC);
    localparam logic [9:0] LEN_PW    = 10'(PW_CYC);

    function automatic logic [9:0] sym_len(input tpp_state_e st, input logic [1:0] s);
        logic [9:0] len;
        case (st)
            S_DELIM: len = LEN_DELIM;
            S_TCAL1: len = LEN_TCAL1;
            S_TCAL2: len = LEN_TCAL2;
            default: begin
                case (s)
                    SYM_00:  len = LEN_D00;
                    SYM_01:  len = LEN_D01;
                    SYM_11:  len = LEN_D11;
                    default: len = LEN_D10;
                endcase
            end
        endcase
        return len;
    endfunction

    // Line level for a given position: high until the closing low pulse.
    function automatic logic wave(input tpp_state_e st, input logic [9:0] c, input logic [1:0] s);
        logic w;
        case (st)
            S_IDLE:  w = 1'b1;
            S_DELIM: w = 1'b0;
            default: w = (c < (sym_len(st, s) - LEN_PW));
        endcase
        return w;
    endfunction

    tpp_state_e state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [1:0] sym_q, sym_d;
    logic       last_q, last_d;
    logic       dout_q, dout_d;
    logic       underrun_q, underrun_d;
    logic [1:0] cur_sym, nxt_sym;
    logic       end_sym;

`ifdef TPP_ENC_CRC16_EN
    logic [15:0] crc_val, crc_sh_q, crc_sh_d;
    logic [2:0]  crc_idx_q, crc_idx_d;

    tpp_crc16 u_crc (
        .dec_clk (dec_clk),
        .clear   ((state_q == S_IDLE) && tx_start),
        .update  (sym_ready && sym_valid),
        .din     (sym_data),
        .crc_out (crc_val)
    );

    assign cur_sym = (state_q == S_CRC) ? crc_sh_q[15:14] : sym_q;
    assign nxt_sym = (state_d == S_CRC) ? crc_sh_d[15:14] : sym_d;
`else
    assign cur_sym = sym_q;
    assign nxt_sym = sym_d;
`endif

    assign end_sym = (cnt_q == (sym_len(state_q, cur_sym) - 10'd1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sym_d      = sym_q;
        last_d     = last_q;
        underrun_d = 1'b0;
        sym_ready  = 1'b0;
        tx_done    = 1'b0;
`ifdef TPP_ENC_CRC16_EN
        crc_sh_d   = crc_sh_q;
        crc_idx_d  = crc_idx_q;
`endif
        if (state_q == S_IDLE) begin
            if (tx_start) begin
                state_d = S_DELIM;
                cnt_d   = 10'd0;
            end
        end else if (!end_sym) begin
            cnt_d = cnt_q + 10'd1;
        end else begin
            cnt_d = 10'd0;
            case (state_q)
                S_DELIM: state_d = S_TCAL1;
                S_TCAL1: state_d = S_TCAL2;
                S_TCAL2, S_DATA: begin
                    if ((state_q == S_DATA) && last_q) begin
`ifdef TPP_ENC_CRC16_EN
                        state_d   = S_CRC;
                        crc_sh_d  = crc_val;
                        crc_idx_d = 3'd0;
`else
                        state_d   = S_IDLE;
                        tx_done   = 1'b1;
`endif
                    end else begin
                        sym_ready = 1'b1;
                        if (sym_valid) begin
                            state_d = S_DATA;
                            sym_d   = sym_data;
                            last_d  = sym_last;
                        end else begin
                            // The rising edge into idle closes the previous symbol cleanly.
                            state_d    = S_IDLE;
                            underrun_d = 1'b1;
                        end
                    end
                end
`ifdef TPP_ENC_CRC16_EN
                S_CRC: begin
                    if (crc_idx_q == 3'd7) begin
                        state_d = S_IDLE;
                        tx_done = 1'b1;
                    end else begin
                        crc_idx_d = crc_idx_q + 3'd1;
                        crc_sh_d  = {crc_sh_q[13:0], 2'b00};
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
        // Output register tracks the next position so tx_dout aligns with state_q/cnt_q.
        dout_d = wave(state_d, cnt_d, nxt_sym);
    end

    always_ff @(posedge dec_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 10'd0;
            last_q     <= 1'b0;
            dout_q     <= 1'b1;
            underrun_q <= 1'b0;
`ifdef TPP_ENC_CRC16_EN
            crc_idx_q  <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            dout_q     <= dout_d;
            underrun_q <= underrun_d;
`ifdef TPP_ENC_CRC16_EN
            crc_idx_q  <= crc_idx_d;
`endif
        end
    end

    always_ff @(posedge dec_clk) begin
        sym_q <= sym_d;
`ifdef TPP_ENC_CRC16_EN
        crc_sh_q <= crc_sh_d;
`endif
    end

    assign tx_dout  = dout_q;
    assign tx_busy  = (state_q != S_IDLE);
    assign underrun = underrun_q;

endmodule

// File: tb/tb_tpp_encoder.sv
// Directed bench for tpp_encoder: waveform run lengths, handshake, underrun, reset.
// The CRC scenario is built only with TPP_ENC_CRC16_EN defined.
module tb_tpp_encoder;

    logic       dec_clk = 1'b0;
    logic       rst_n, tx_start, sym_valid, sym_last;
    logic [1:0] sym_data;
    logic       sym_ready, tx_dout, tx_busy, tx_done, underrun;

    tpp_encoder #(.U_CYC(8), .PW_CYC(12), .DELIM_CYC(24)) dut (
        .dec_clk   (dec_clk),
        .rst_n     (rst_n),
        .tx_start  (tx_start),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .sym_last  (sym_last),
        .sym_ready (sym_ready),
        .tx_dout   (tx_dout),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .underrun  (underrun)
    );

    always #5 dec_clk = ~dec_clk;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int edges[$];
    int rises[$];
    logic [1:0] src_q[$];
    logic prev_dout = 1'b1;
    int n_ready, n_done, n_under, n_busy, done_cyc;
    logic under_dout, under_busy;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        edges.delete();
        rises.delete();
        n_ready = 0; n_done = 0; n_under = 0; n_busy = 0; done_cyc = -1;
        under_dout = 1'b0; under_busy = 1'b1;
        prev_dout = tx_dout;
    endtask

    // Sample on the falling edge, then present the next source symbol.
    task automatic tick();
        @(negedge dec_clk);
        cyc++;
        if (tx_dout !== prev_dout) begin
            edges.push_back(cyc);
            if (tx_dout) rises.push_back(cyc);
        end
        prev_dout = tx_dout;
        if (sym_ready) n_ready++;
        if (tx_busy) n_busy++;
        if (tx_done) begin n_done++; done_cyc = cyc; end
        if (underrun) begin n_under++; under_dout = tx_dout; under_busy = tx_busy; end
        sym_valid = (src_q.size() > 0);
        sym_data  = sym_valid ? src_q[0] : 2'b00;
        sym_last  = (src_q.size() == 1);
        if (sym_ready && sym_valid) void'(src_q.pop_front());
    endtask

    task automatic run_frame(input int budget, input int inject_at, input bit start_on_done);
        bit injected;
        injected = 1'b0;
        clear_mon();
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check("start_dout", tx_dout, 0);
        check("start_busy", tx_busy, 1);
        for (int i = 0; i < budget && n_done == 0 && n_under == 0; i++) begin
            tx_start = 1'b0;
            if (inject_at > 0 && !injected && rises.size() == inject_at) begin
                tx_start = 1'b1;
                injected = 1'b1;
            end
            tick();
        end
        tx_start = 1'b0;
        if (n_done == 0 && n_under == 0) check("frame_timeout", 1, 0);
        if (start_on_done && n_done == 1) begin
            tx_start = 1'b1;
            tick();
            tx_start = 1'b0;
            tick();
            check("start_on_done_ignored", tx_busy, 0);
        end
        repeat (4) tick();
    endtask

    task automatic check_spacing(input string tag, input int q[$], input int exp[$]);
        check({tag, "_count"}, q.size(), exp.size() + 1);
        if (q.size() == exp.size() + 1) begin
            for (int i = 0; i < exp.size(); i++) begin
                check($sformatf("%s%0d", tag, i), q[i+1] - q[i], exp[i]);
            end
        end
    endtask

    initial begin
        int exp_runs[$];
        int exp_sp[$];
        int guard;
        rst_n = 1'b1; tx_start = 1'b0; sym_valid = 1'b0; sym_last = 1'b0; sym_data = 2'b00;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_dout", tx_dout, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_ready", sym_ready, 0);
        check("rst_underrun", underrun, 0);
        rst_n = 1'b1;

        clear_mon();
        repeat (1000) tick();
        check("idle_edges", edges.size(), 0);
        check("idle_busy", n_busy, 0);
        check("idle_ready", n_ready + n_done + n_under, 0);

`ifndef TPP_ENC_CRC16_EN
        // Single 00 symbol: low 24, high 116, low 12, high 52, low 12, high 20, low 12.
        src_q = '{2'b00};
        run_frame(1000, 0, 1'b0);
        exp_runs = '{24, 116, 12, 52, 12, 20, 12};
        check_spacing("one_run", edges, exp_runs);
        if (edges.size() == 8) check("one_done_cyc", done_cyc, edges[7] - 1);
        check("one_done_cnt", n_done, 1);
        check("one_ready_cnt", n_ready, 1);

        // Four symbols with a stray tx_start during DATA, and one coincident with tx_done.
        src_q = '{2'b00, 2'b01, 2'b11, 2'b10};
        run_frame(2000, 4, 1'b1);
        exp_sp = '{128, 64, 32, 56, 72, 88};
        check_spacing("four_sp", rises, exp_sp);
        check("four_ready_cnt", n_ready, 4);
        check("four_done_cnt", n_done, 1);
        check("four_under_cnt", n_under, 0);
        if (edges.size() > 0 && rises.size() > 2) check("first_data_rise", rises[2] - edges[0], 216);
`endif

        // Underrun at the first data request.
        src_q.delete();
        run_frame(1000, 0, 1'b0);
        check("ur_pulse", n_under, 1);
        check("ur_dout", under_dout, 1);
        check("ur_busy", under_busy, 0);
        check("ur_done", n_done, 0);
        check("ur_ready", n_ready, 1);
        exp_sp = '{128, 64};
        check_spacing("ur_sp", rises, exp_sp);

        // Asynchronous reset while a data pulse is low.
        src_q = '{2'b11, 2'b11, 2'b11};
        clear_mon();
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        guard = 0;
        while (guard < 1000 && !(rises.size() >= 3 && tx_dout == 1'b0)) begin
            tick();
            guard++;
        end
        check("abort_reached", guard < 1000, 1);
        check("abort_pre_dout", tx_dout, 0);
        #1 rst_n = 1'b0;
        #1;
        check("abort_dout", tx_dout, 1);
        check("abort_busy", tx_busy, 0);
        check("abort_ready", sym_ready, 0);
        src_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("abort_stays_idle", tx_busy, 0);

`ifndef TPP_ENC_CRC16_EN
        src_q = '{2'b00};
        run_frame(1000, 0, 1'b0);
        exp_runs = '{24, 116, 12, 52, 12, 20, 12};
        check_spacing("post_run", edges, exp_runs);
        check("post_done_cnt", n_done, 1);
`else
        // Data 0x00 gives CRC symbols 00,01,11,10,00,00,11,11 after the data.
        src_q = '{2'b00, 2'b00, 2'b00, 2'b00};
        run_frame(3000, 0, 1'b0);
        exp_sp = '{128, 64, 32, 32, 32, 32, 32, 56, 72, 88, 32, 32, 72, 72};
        check_spacing("crc_sp", rises, exp_sp);
        check("crc_ready_cnt", n_ready, 4);
        check("crc_done_cnt", n_done, 1);
        if (rises.size() == 15) check("crc_done_cyc", done_cyc, rises[14] - 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
